// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for an LSU.
// Accepts one load/store request in IDLE, waits LATENCY cycles, performs
// the access against an internal word array with byte-lane stores and
// sign/zero-extended loads, then holds the response until it is accepted.
//
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag misaligned
// half/word accesses with resp_err_o instead of silently aligning them.
//
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   req_valid_i / req_ready_o       request handshake
//   req_we_i, req_size_i,
//   req_unsigned_i, req_addr_i,
//   req_wdata_i                     request payload
//   resp_valid_o / resp_ready_i     response handshake
//   resp_rdata_o, resp_err_o        response payload
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          execute;
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          misalign;
    logic [3:0]    wmask;
    logic [31:0]   wdata_sh;
    logic          unused_addr;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] o);
        case (size)
            2'b00:   lane_mask = 4'b0001 << o;
            2'b01:   lane_mask = 4'b0011 << o;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Shift the addressed byte/half down to bit 0, then extend to 32 bits.
    function automatic logic [31:0] extend(input logic [1:0] size, input logic uns,
                                           input logic [31:0] word, input logic [1:0] o);
        logic [31:0] sh;
        sh = word >> {o, 3'b000};
        case (size)
            2'b00:   extend = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   extend = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: extend = sh;
        endcase
    endfunction

    assign req_ready_o  = (state == IDLE) && !reset_i;
    assign accept       = req_valid_i && req_ready_o;
    assign execute      = (state == WAIT) && (cnt == 4'd0);
    assign idx          = addr_q[AW+1:2];
    assign unused_addr  = ^{addr_q[31:AW+2]};
    assign resp_valid_o = (state == RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

    // Effective byte offset inside the word, and misalignment detection.
    always_comb begin
        off      = addr_q[1:0];
        misalign = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        case (size_q)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = addr_q[0];
            default: misalign = (addr_q[1:0] != 2'b00);
        endcase
`else
        case (size_q)
            2'b00:   off = addr_q[1:0];
            2'b01:   off = {addr_q[1], 1'b0};
            default: off = 2'b00;
        endcase
`endif
    end

    assign wmask    = lane_mask(size_q, off);
    assign wdata_sh = wdata_q << {off, 3'b000};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = WAIT;
                    cnt_n   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_n = RESP;
                else             cnt_n   = cnt - 4'd1;
            end
            RESP: begin
                if (resp_ready_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request payload is only meaningful while a request is outstanding.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (execute) begin
            err_q   <= misalign;
            rdata_q <= (we_q || misalign) ? 32'd0 : extend(size_q, uns_q, mem[idx], off);
        end
    end

    // Reset on the execute edge suppresses the store commit.
    always_ff @(posedge clk_i) begin
        if (!reset_i && execute && we_q && !misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a response scoreboard.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;

    int checks = 0;
    int fails  = 0;

    logic [32:0] sb [$];

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction: accept, latency check, optional backpressure, handshake.
    task automatic xact(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int k;
        logic [32:0] e;
        k = 0;
        while (!req_ready_o && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        chk({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        @(posedge clk_i);
        sb.push_back({exp_err, exp_rdata});
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_wdata_i = 32'hCAFEF00D;
        k = 0;
        while (!resp_valid_o && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        chk({tag, "_latency"}, k, LAT);
        e = sb.pop_front();
        chk({tag, "_rdata"}, resp_rdata_o, e[31:0]);
        chk({tag, "_err"}, {31'd0, resp_err_o}, {31'd0, e[32]});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            chk({tag, "_hold_valid"}, {31'd0, resp_valid_o}, 32'd1);
            chk({tag, "_hold_rdata"}, resp_rdata_o, e[31:0]);
            chk({tag, "_hold_err"}, {31'd0, resp_err_o}, {31'd0, e[32]});
            chk({tag, "_hold_reqrdy"}, {31'd0, req_ready_o}, 32'd0);
        end
        resp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        chk({tag, "_post_valid"}, {31'd0, resp_valid_o}, 32'd0);
        chk({tag, "_post_reqrdy"}, {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        reset_i        = 1'b1;
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i     = 32'd0;
        req_wdata_i    = 32'd0;
        resp_ready_i   = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_reqrdy", {31'd0, req_ready_o}, 32'd0);
        chk("rst_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("rst_rdata", resp_rdata_o, 32'd0);
        chk("rst_err", {31'd0, resp_err_o}, 32'd0);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_release_reqrdy", {31'd0, req_ready_o}, 32'd1);

        // we, size, uns, addr, wdata, rdata, err, hold
        xact("sw_init4",  1'b1, 2'b10, 1'b0, 32'h4,   32'h0,        32'h0,        1'b0, 0);
        xact("sb4",       1'b1, 2'b00, 1'b0, 32'h4,   32'h0000FFFF, 32'h0,        1'b0, 0);
        xact("lb4",       1'b0, 2'b00, 1'b0, 32'h4,   32'h0,        32'hFFFFFFFF, 1'b0, 0);
        xact("lbu4",      1'b0, 2'b00, 1'b1, 32'h4,   32'h0,        32'h000000FF, 1'b0, 0);
        xact("lb5",       1'b0, 2'b00, 1'b0, 32'h5,   32'h0,        32'h00000000, 1'b0, 0);
        xact("sw8",       1'b1, 2'b10, 1'b0, 32'h8,   32'h12345678, 32'h0,        1'b0, 0);
        xact("lha",       1'b0, 2'b01, 1'b0, 32'hA,   32'h0,        32'h00001234, 1'b0, 0);
        xact("lbu9",      1'b0, 2'b00, 1'b1, 32'h9,   32'h0,        32'h00000056, 1'b0, 0);
        xact("lh8",       1'b0, 2'b01, 1'b0, 32'h8,   32'h0,        32'h00005678, 1'b0, 0);
        xact("sha",       1'b1, 2'b01, 1'b0, 32'hA,   32'hFFFF8001, 32'h0,        1'b0, 0);
        xact("lha_neg",   1'b0, 2'b01, 1'b0, 32'hA,   32'h0,        32'hFFFF8001, 1'b0, 0);
        xact("lhua",      1'b0, 2'b01, 1'b1, 32'hA,   32'h0,        32'h00008001, 1'b0, 0);
        xact("sbb",       1'b1, 2'b00, 1'b0, 32'hB,   32'h0000007F, 32'h0,        1'b0, 0);
        xact("lw8",       1'b0, 2'b10, 1'b0, 32'h8,   32'h0,        32'h7F015678, 1'b0, 0);
        xact("lw_wrap",   1'b0, 2'b10, 1'b0, 32'h408, 32'h0,        32'h7F015678, 1'b0, 0);
        xact("lsize3",    1'b0, 2'b11, 1'b0, 32'h8,   32'h0,        32'h7F015678, 1'b0, 0);
        xact("bp_lw8",    1'b0, 2'b10, 1'b0, 32'h8,   32'h0,        32'h7F015678, 1'b0, 5);
        xact("bp_sw",     1'b1, 2'b10, 1'b0, 32'hC,   32'h55AA55AA, 32'h0,        1'b0, 5);

`ifdef DMEM_MISALIGN_CHECK_EN
        xact("sw6_mis",   1'b1, 2'b10, 1'b0, 32'h6,   32'hDEADBEEF, 32'h0,        1'b1, 0);
        xact("lw4_keep",  1'b0, 2'b10, 1'b0, 32'h4,   32'h0,        32'h000000FF, 1'b0, 0);
        xact("lh9_mis",   1'b0, 2'b01, 1'b0, 32'h9,   32'h0,        32'h0,        1'b1, 0);
`else
        xact("sw6_align", 1'b1, 2'b10, 1'b0, 32'h6,   32'hDEADBEEF, 32'h0,        1'b0, 0);
        xact("lw4_new",   1'b0, 2'b10, 1'b0, 32'h4,   32'h0,        32'hDEADBEEF, 1'b0, 0);
        xact("lh9_align", 1'b0, 2'b01, 1'b0, 32'h9,   32'h0,        32'h00005678, 1'b0, 0);
`endif

        // Reset during WAIT of a store: the store must not land.
        xact("sw10_init", 1'b1, 2'b10, 1'b0, 32'h10,  32'h11111111, 32'h0,        1'b0, 0);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_size_i  = 2'b10;
        req_addr_i  = 32'h10;
        req_wdata_i = 32'hAAAAAAAA;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        reset_i     = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("abort_valid", {31'd0, resp_valid_o}, 32'd0);
            chk("abort_reqrdy", {31'd0, req_ready_o}, 32'd0);
        end
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("abort_reqrdy_after", {31'd0, req_ready_o}, 32'd1);
        chk("abort_valid_after", {31'd0, resp_valid_o}, 32'd0);
        xact("lw10",      1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h11111111, 1'b0, 0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
